// File: rtl/uart_deframe_pkg.sv
// uart_deframe_pkg
// Shared definitions for the UART receive-side deframer:
//   - deframer state encoding (enum plus plain localparam constants)
//   - default start-of-frame marker
//   - 8-bit additive checksum helper
package uart_deframe_pkg;

  typedef enum logic [2:0] {
    ST_HUNT    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CSUM    = 3'd3,
    ST_DRAIN   = 3'd4
  } state_e;

  localparam logic [2:0] S_HUNT    = 3'(ST_HUNT);
  localparam logic [2:0] S_LEN     = 3'(ST_LEN);
  localparam logic [2:0] S_PAYLOAD = 3'(ST_PAYLOAD);
  localparam logic [2:0] S_CSUM    = 3'(ST_CSUM);
  localparam logic [2:0] S_DRAIN   = 3'(ST_DRAIN);

  localparam logic [7:0] DEFAULT_SOF = 8'hA5;

  // Running checksum accumulate; wraps modulo 256.
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/uart_deframe_buf.sv
// uart_deframe_buf
// DEPTH x 8 payload buffer: one synchronous write port, one combinational
// read port. Contents are not reset.
// Ports:
//   clk    in   clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write byte
//   raddr  in   read address
//   rdata  out  byte at raddr
module uart_deframe_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer
// Hunts for SOF_BYTE, collects a LEN-prefixed payload into a buffer, checks
// the 8-bit additive checksum (LEN + payload + CSUM == 0 mod 256) and only
// then replays the payload as a ready/valid byte stream.
//
// Optional feature macro: UART_DEFRAME_TIMEOUT_EN enables the inter-byte
// timeout (timeout_err). Without it timeout_err is tied low.
//
// Handshake: a byte transfers on a rising PCLK edge where out_valid and
// out_ready are both high; out_data/out_last hold while out_valid is high and
// out_ready is low; out_valid never drops without a transfer except on reset.
//
// Ports:
//   PCLK, PRESET         clock, synchronous active-high reset
//   rx_data/rx_valid     received byte and its one-cycle strobe
//   rx_err               one-cycle receive error strobe
//   out_data/out_valid/out_ready/out_last   verified payload stream
//   busy                 high whenever the FSM is not hunting
//   csum_err, len_err, abort_err, drop, timeout_err   one-cycle pulses
//   fsm_state            current FSM state (debug observation)
module uart_rx_deframer
  import uart_deframe_pkg::*;
#(
  parameter int         MAX_LEN        = 16,
  parameter logic [7:0] SOF_BYTE       = DEFAULT_SOF,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_err,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       busy,
  output logic       csum_err,
  output logic       len_err,
  output logic       abort_err,
  output logic       drop,
  output logic       timeout_err,
  output logic [2:0] fsm_state
);

  localparam int         IW        = $clog2(MAX_LEN + 1);
  localparam int         BW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  logic [2:0]    state;
  logic [IW-1:0] idx;
  logic [IW-1:0] rd_idx;
  logic [7:0]    sum;
  logic [7:0]    len;
  logic [7:0]    rd_data;
  logic          buf_we;
  logic          in_frame;

  assign in_frame = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CSUM);
  assign buf_we   = (state == S_PAYLOAD) && rx_valid && !rx_err;

  uart_deframe_buf #(.DEPTH(MAX_LEN), .AW(BW)) u_buf (
    .clk   (PCLK),
    .we    (buf_we),
    .waddr (BW'(idx)),
    .wdata (rx_data),
    .raddr (BW'(rd_idx)),
    .rdata (rd_data)
  );

  // Stream outputs decode directly from state flops so they are zero outside DRAIN.
  assign out_valid = (state == S_DRAIN);
  assign out_data  = out_valid ? rd_data : 8'h00;
  assign out_last  = out_valid && (8'(rd_idx) == len - 8'd1);
  assign busy      = (state != S_HUNT);
  assign fsm_state = state;

`ifdef UART_DEFRAME_TIMEOUT_EN
  localparam int            TW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] timer;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_err        = 1'b0;
`endif

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state     <= S_HUNT;
      idx       <= '0;
      rd_idx    <= '0;
      sum       <= '0;
      len       <= '0;
      csum_err  <= 1'b0;
      len_err   <= 1'b0;
      abort_err <= 1'b0;
      drop      <= 1'b0;
`ifdef UART_DEFRAME_TIMEOUT_EN
      timer       <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      csum_err  <= 1'b0;
      len_err   <= 1'b0;
      abort_err <= 1'b0;
      drop      <= 1'b0;

      case (state)
        S_HUNT: begin
          if (rx_valid && (rx_data == SOF_BYTE)) state <= S_LEN;
        end
        S_LEN: begin
          if (rx_err) begin
            abort_err <= 1'b1;
            state     <= S_HUNT;
          end else if (rx_valid) begin
            if ((rx_data == 8'h00) || (rx_data > MAX_LEN_B)) begin
              len_err <= 1'b1;
              state   <= S_HUNT;
            end else begin
              len   <= rx_data;
              sum   <= rx_data;
              idx   <= '0;
              state <= S_PAYLOAD;
            end
          end
        end
        S_PAYLOAD: begin
          if (rx_err) begin
            abort_err <= 1'b1;
            state     <= S_HUNT;
          end else if (rx_valid) begin
            sum <= csum_add(sum, rx_data);
            idx <= idx + 1'b1;
            if (8'(idx) == len - 8'd1) state <= S_CSUM;
          end
        end
        S_CSUM: begin
          if (rx_err) begin
            abort_err <= 1'b1;
            state     <= S_HUNT;
          end else if (rx_valid) begin
            if (csum_add(sum, rx_data) == 8'h00) begin
              rd_idx <= '0;
              state  <= S_DRAIN;
            end else begin
              csum_err <= 1'b1;
              state    <= S_HUNT;
            end
          end
        end
        S_DRAIN: begin
          // No frame overlap: anything received while replaying is discarded.
          if (rx_valid) drop <= 1'b1;
          if (out_ready) begin
            rd_idx <= rd_idx + 1'b1;
            if (out_last) state <= S_HUNT;
          end
        end
        default: state <= S_HUNT;
      endcase

`ifdef UART_DEFRAME_TIMEOUT_EN
      // A byte (or a receive error) in the expiry cycle takes precedence.
      timeout_err <= 1'b0;
      if (rx_valid || !in_frame) begin
        timer <= '0;
      end else if (timer == TMAX) begin
        timer <= '0;
        if (!rx_err) begin
          timeout_err <= 1'b1;
          state       <= S_HUNT;
        end
      end else begin
        timer <= timer + 1'b1;
      end
`endif
    end
  end

`ifndef UART_DEFRAME_TIMEOUT_EN
  logic unused_in_frame;
  assign unused_in_frame = in_frame;
`endif

endmodule
